// File: rtl/onchip_memory_ram_pipelined_if.sv
// Avalon-MM slave bus bundle for onchip_memory_ram_pipelined.
interface onchip_memory_ram_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
) ();
  logic                    chipselect;
  logic [ADDR_WIDTH-1:0]   address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;
  logic                    addr_err;

  modport master (
    output chipselect, address, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest, addr_err
  );

  modport slave (
    input  chipselect, address, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest, addr_err
  );
endinterface

// File: rtl/onchip_memory_ram_pipelined.sv
// Single-port on-chip RAM, Avalon-MM slave, READ_LATENCY 1 or 2.
// Define ONCHIP_RAM_CLEAR_ON_RESET_EN to zero every word after reset before accepting traffic.
module onchip_memory_ram_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int DEPTH        = 30000,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "onchip_memory_ram.hex"
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_req,
  input  logic clken,
  input  logic freeze,
  onchip_memory_ram_pipelined_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  localparam logic [1:0] ST_RST   = 2'd0;
`ifdef ONCHIP_RAM_CLEAR_ON_RESET_EN
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);
`endif
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0] state;

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic in_range, acc, wr_acc, rd_acc;
  logic ram_we;
  logic [ADDR_WIDTH-1:0] ram_wa;
  logic [DATA_WIDTH-1:0] ram_wd;
  logic [NB-1:0] ram_be;

  logic [READ_LATENCY:1] vld_pipe;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;
  logic err_q;

  // reset also gates acceptance so nothing slips in before the FSM reaches RST
  assign bus.waitrequest = reset | (state != ST_RUN) | reset_req | ~clken;
  assign in_range = {1'b0, bus.address} < DEPTH_L;
  assign acc      = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
  assign wr_acc   = acc & bus.write;
  assign rd_acc   = acc & bus.read & ~bus.write;

`ifdef ONCHIP_RAM_CLEAR_ON_RESET_EN
  logic [ADDR_WIDTH-1:0] sweep_addr;

  always_ff @(posedge clk) begin
    if (reset || state == ST_RST) sweep_addr <= '0;
    else if (state == ST_SWEEP)   sweep_addr <= sweep_addr + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RST;
    else begin
      case (state)
`ifdef ONCHIP_RAM_CLEAR_ON_RESET_EN
        ST_RST:   state <= ST_SWEEP;
        ST_SWEEP: if (sweep_addr == LAST_WORD) state <= ST_RUN;
`else
        ST_RST:   state <= ST_RUN;
`endif
        ST_RUN:   state <= ST_RUN;
        default:  state <= ST_RST;
      endcase
    end
  end

  // one shared write port: the sweep owns it until RUN
  always_comb begin
    ram_we = wr_acc & in_range & ~freeze;
    ram_wa = bus.address;
    ram_wd = bus.writedata;
    ram_be = bus.byteenable;
`ifdef ONCHIP_RAM_CLEAR_ON_RESET_EN
    if (state == ST_SWEEP) begin
      ram_we = 1'b1;
      ram_wa = sweep_addr;
      ram_wd = '0;
      ram_be = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < NB; i++)
        if (ram_be[i]) mem[ram_wa][8*i +: 8] <= ram_wd[8*i +: 8];
    end
  end

  // data stages only load on a live read so readdata keeps the last returned word
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (clken) begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) dat_pipe[1] <= in_range ? mem[bus.address] : '0;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= acc & ~in_range;
  end

  assign bus.readdata      = dat_pipe[READ_LATENCY];
  assign bus.readdatavalid = vld_pipe[READ_LATENCY];
  assign bus.addr_err      = err_q;
endmodule

// File: tb/tb_onchip_memory_ram_pipelined.sv
// Bench for onchip_memory_ram_pipelined: latency-1 and latency-2 instances share one stimulus stream.
module tb_onchip_memory_ram_pipelined;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int DEPTH = 30000;
`ifdef ONCHIP_RAM_CLEAR_ON_RESET_EN
  localparam int INIT_WAIT = DEPTH + 1;
`else
  localparam int INIT_WAIT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, reset_req = 1'b0, clken = 1'b1, freeze = 1'b0;
  logic cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0] be = '0;
  logic [31:0] wd = '0;

  always #5 clk = ~clk;

  onchip_memory_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  onchip_memory_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

  assign b1.chipselect = cs;  assign b2.chipselect = cs;
  assign b1.address    = addr; assign b2.address   = addr;
  assign b1.read       = rd;  assign b2.read       = rd;
  assign b1.write      = wr;  assign b2.write      = wr;
  assign b1.byteenable = be;  assign b2.byteenable = be;
  assign b1.writedata  = wd;  assign b2.writedata  = wd;

  onchip_memory_ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .freeze(freeze), .bus(b1));
  onchip_memory_ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .freeze(freeze), .bus(b2));

  // reference model: word store with per-byte known mask, reads keyed by clken-edge stamp
  typedef struct { logic [31:0] d; bit k; } pend_t;
  pend_t       pend [int];
  logic [31:0] ref_mem [int];
  logic [3:0]  ref_kn [int];
  bit cleared = 1'b0;
  bit ready = 1'b0;
  int wait_left = INIT_WAIT;
  int ce = 0;
  bit ev [2];
  bit ek [2];
  logic [31:0] ed [2];
  bit xerr = 1'b0;

  int n_chk = 0, n_pass = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  function automatic pend_t rd_entry(input int a);
    pend_t e;
    e.d = '0;
    e.k = 1'b1;
    if (a < DEPTH) begin
      if (ref_kn.exists(a) && ref_kn[a] == 4'hF) e.d = ref_mem[a];
      else if (!cleared || ref_kn.exists(a)) e.k = 1'b0;
    end
    return e;
  endfunction

  task automatic merge(input int a, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] w;
    logic [3:0] kn;
    w  = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    kn = ref_kn.exists(a) ? ref_kn[a] : (cleared ? 4'hF : 4'h0);
    for (int i = 0; i < 4; i++)
      if (m[i]) begin w[8*i +: 8] = d[8*i +: 8]; kn[i] = 1'b1; end
    ref_mem[a] = w;
    ref_kn[a]  = kn;
  endtask

  // one clock: model update at the edge, DUT comparison on the following falling edge
  task automatic step();
    bit acc, inr;
    bit xw;
    @(posedge clk);
    inr = int'(addr) < DEPTH;
    acc = cs && (rd || wr) && ready && !reset_req && clken && !reset;
    if (reset) begin
      ready = 1'b0; wait_left = INIT_WAIT; pend.delete();
      ev = '{0, 0}; ek = '{1, 1}; ed = '{32'h0, 32'h0}; xerr = 1'b0;
    end else begin
      if (!ready) begin
        wait_left--;
        if (wait_left == 0) begin
          ready = 1'b1;
`ifdef ONCHIP_RAM_CLEAR_ON_RESET_EN
          ref_mem.delete(); ref_kn.delete(); cleared = 1'b1;
`endif
        end
      end
      xerr = acc && !inr;
      if (acc && wr && inr && !freeze) merge(int'(addr), be, wd);
      if (clken) begin
        ce++;
        if (acc && rd && !wr) pend[ce] = rd_entry(int'(addr));
        for (int k = 0; k < 2; k++) begin
          if (pend.exists(ce - k)) begin
            ev[k] = 1'b1; ed[k] = pend[ce-k].d; ek[k] = pend[ce-k].k;
          end else ev[k] = 1'b0;
        end
        if (pend.exists(ce - 2)) pend.delete(ce - 2);
      end
    end
    @(negedge clk);
    xw = !ready || reset_req || !clken || reset;
    chk1("wait_l1", b1.waitrequest, xw);
    chk1("wait_l2", b2.waitrequest, xw);
    chk1("valid_l1", b1.readdatavalid, ev[0]);
    chk1("valid_l2", b2.readdatavalid, ev[1]);
    chk1("err_l1", b1.addr_err, xerr);
    chk1("err_l2", b2.addr_err, xerr);
    if (ev[0] && ek[0]) chk32("data_l1", b1.readdata, ed[0]);
    if (ev[1] && ek[1]) chk32("data_l2", b2.readdata, ed[1]);
  endtask

  task automatic count_wait(output int n);
    n = 0;
    do begin step(); n++; end while (b1.waitrequest && n < INIT_WAIT + 16);
  endtask

  typedef struct {
    bit wr, rd, frz, err;
    logic [AW-1:0] a;
    logic [3:0] be;
    logic [31:0] wd, exp;
  } vec_t;

  function automatic vec_t mk(input bit w, input bit r, input bit f, input int a,
                              input logic [3:0] m, input logic [31:0] d,
                              input logic [31:0] x, input bit e);
    vec_t v;
    v.wr = w; v.rd = r; v.frz = f; v.a = AW'(a); v.be = m; v.wd = d; v.exp = x; v.err = e;
    return v;
  endfunction

  task automatic xact(input int idx, input vec_t v);
    int lat1 = 0, lat2 = 0;
    logic [31:0] d1 = '0, d2 = '0;
    logic e1 = 1'b0, e2 = 1'b0;
    cs = 1'b1; rd = v.rd; wr = v.wr; addr = v.a; be = v.be; wd = v.wd; freeze = v.frz;
    for (int n = 1; n <= 4; n++) begin
      step();
      if (n == 1) begin
        e1 = b1.addr_err; e2 = b2.addr_err;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; freeze = 1'b0;
      end
      if (lat1 == 0 && b1.readdatavalid) begin lat1 = n; d1 = b1.readdata; end
      if (lat2 == 0 && b2.readdatavalid) begin lat2 = n; d2 = b2.readdata; end
    end
    chk1($sformatf("v%0d_aerr_l1", idx), e1, v.err);
    chk1($sformatf("v%0d_aerr_l2", idx), e2, v.err);
    if (v.rd && !v.wr) begin
      chk32($sformatf("v%0d_lat_l1", idx), 32'(lat1), 32'd1);
      chk32($sformatf("v%0d_lat_l2", idx), 32'(lat2), 32'd2);
      chk32($sformatf("v%0d_rdata_l1", idx), d1, v.exp);
      chk32($sformatf("v%0d_rdata_l2", idx), d2, v.exp);
    end else begin
      chk32($sformatf("v%0d_novalid", idx), 32'(lat1 + lat2), 32'd0);
    end
  endtask

  vec_t tbl [22];
  bit          bv1 [7] = '{1, 1, 1, 1, 1, 0, 0};
  bit          bv2 [7] = '{0, 1, 1, 1, 1, 1, 0};
  logic [31:0] bd1 [7] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hB2B2B2B2, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'h0, 32'h0};
  logic [31:0] bd2 [7] = '{32'h0, 32'hA1A1A1A1, 32'hA1A1A1A1, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'h0};

  initial begin
    int n;
    int r;
    tbl[0]  = mk(1, 0, 0, 5,     4'hF, 32'hDEADBEEF, 32'h0,        0);
    tbl[1]  = mk(0, 1, 0, 5,     4'hF, 32'h0,        32'hDEADBEEF, 0);
    tbl[2]  = mk(1, 0, 0, 7,     4'hF, 32'hFFFFFFFF, 32'h0,        0);
    tbl[3]  = mk(1, 0, 0, 7,     4'h5, 32'h12345678, 32'h0,        0);
    tbl[4]  = mk(0, 1, 0, 7,     4'hF, 32'h0,        32'hFF34FF78, 0);
    tbl[5]  = mk(1, 0, 0, 0,     4'hF, 32'hA5A5A5A5, 32'h0,        0);
    tbl[6]  = mk(1, 0, 0, DEPTH, 4'hF, 32'h11111111, 32'h0,        1);
    tbl[7]  = mk(0, 1, 0, DEPTH, 4'hF, 32'h0,        32'h0,        1);
    tbl[8]  = mk(0, 1, 0, 0,     4'hF, 32'h0,        32'hA5A5A5A5, 0);
    tbl[9]  = mk(1, 0, 0, 1,     4'hF, 32'hA1A1A1A1, 32'h0,        0);
    tbl[10] = mk(1, 0, 0, 2,     4'hF, 32'hB2B2B2B2, 32'h0,        0);
    tbl[11] = mk(1, 0, 0, 3,     4'hF, 32'hC3C3C3C3, 32'h0,        0);
    tbl[12] = mk(1, 0, 1, 1,     4'hF, 32'hFFFFFFFF, 32'h0,        0);
    tbl[13] = mk(0, 1, 0, 1,     4'hF, 32'h0,        32'hA1A1A1A1, 0);
    tbl[14] = mk(1, 0, 0, 3,     4'h0, 32'h00000000, 32'h0,        0);
    tbl[15] = mk(0, 1, 0, 3,     4'hF, 32'h0,        32'hC3C3C3C3, 0);
    tbl[16] = mk(1, 1, 0, 5,     4'hF, 32'h0BADF00D, 32'h0,        0);
    tbl[17] = mk(0, 1, 0, 5,     4'hF, 32'h0,        32'h0BADF00D, 0);
    tbl[18] = mk(1, 0, 0, 32767, 4'hF, 32'h0,        32'h0,        1);
    tbl[19] = mk(0, 1, 0, 32767, 4'hF, 32'h0,        32'h0,        1);
    tbl[20] = mk(1, 0, 0, 9,     4'hF, 32'h99999999, 32'h0,        0);
    tbl[21] = mk(0, 1, 0, 9,     4'hF, 32'h0,        32'h99999999, 0);

    // reset state
    for (int i = 0; i < 3; i++) step();
    chk32("rst_rdata_l1", b1.readdata, 32'h0);
    chk32("rst_rdata_l2", b2.readdata, 32'h0);
    reset = 1'b0;
    count_wait(n);
    chk32("init_wait_len", 32'(n), 32'(INIT_WAIT));

    // preload a small window with random words
    for (int a = 0; a < 16; a++) begin
      cs = 1'b1; wr = 1'b1; addr = AW'(a); be = 4'hF; wd = $urandom;
      step();
    end
    cs = 1'b0; wr = 1'b0;
    step();

    foreach (tbl[i]) xact(i, tbl[i]);

    // write then read the same word on the very next cycle
    cs = 1'b1; wr = 1'b1; addr = AW'(6); be = 4'hF; wd = 32'h66660006;
    step();
    wr = 1'b0; rd = 1'b1;
    step();
    chk32("raw_l1", b1.readdata, 32'h66660006);
    cs = 1'b0; rd = 1'b0;
    step();
    chk32("raw_l2", b2.readdata, 32'h66660006);
    step();

    // back-to-back reads with a 2-cycle clken stall mid-burst
    for (int s = 0; s < 7; s++) begin
      cs = (s < 5); rd = (s < 5); addr = AW'(s < 2 ? s + 1 : 3);
      clken = !(s == 2 || s == 3);
      step();
      chk1($sformatf("burst%0d_v_l1", s), b1.readdatavalid, bv1[s]);
      chk1($sformatf("burst%0d_v_l2", s), b2.readdatavalid, bv2[s]);
      if (bv1[s]) chk32($sformatf("burst%0d_d_l1", s), b1.readdata, bd1[s]);
      if (bv2[s]) chk32($sformatf("burst%0d_d_l2", s), b2.readdata, bd2[s]);
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cs = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 9);
      rd = (r <= 4) || (r == 9);
      wr = (r >= 5);
      if ($urandom_range(0, 9) == 0) addr = ($urandom_range(0, 4) == 0) ? AW'(32767) : AW'(DEPTH + $urandom_range(0, 3));
      else addr = AW'($urandom_range(0, 15));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      clken = $urandom_range(0, 9) != 0;
      freeze = $urandom_range(0, 9) == 0;
      reset_req = $urandom_range(0, 19) == 0;
      step();
    end
    cs = 1'b0; rd = 1'b0; wr = 1'b0; clken = 1'b1; freeze = 1'b0; reset_req = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // reset with reads in flight
    cs = 1'b1; rd = 1'b1; addr = AW'(1);
    step();
    addr = AW'(2);
    step();
    reset = 1'b1; cs = 1'b0; rd = 1'b0;
    step();
    chk1("rstfl_v_l1", b1.readdatavalid, 1'b0);
    chk1("rstfl_v_l2", b2.readdatavalid, 1'b0);
    chk1("rstfl_wait", b1.waitrequest, 1'b1);
    chk32("rstfl_rdata_l2", b2.readdata, 32'h0);
    step();
    reset = 1'b0;
`ifdef ONCHIP_RAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 1000; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif
    count_wait(n);
    chk32("rst_release_len", 32'(n), 32'(INIT_WAIT));
`ifdef ONCHIP_RAM_CLEAR_ON_RESET_EN
    xact(100, mk(0, 1, 0, 9, 4'hF, 32'h0, 32'h0, 0));
`endif

    // reset_req blocks accepts
    reset_req = 1'b1; cs = 1'b1; rd = 1'b1; addr = AW'(5);
    step();
    chk1("rreq_wait_l1", b1.waitrequest, 1'b1);
    step();
    chk1("rreq_novalid_l1", b1.readdatavalid, 1'b0);
    reset_req = 1'b0; cs = 1'b0; rd = 1'b0;
    for (int i = 0; i < 3; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
